// File: rtl/fos_pkg.sv
// rtl/fos_pkg.sv - shared defaults and quantiser helper for the IIR output stage
//
// Purpose: default widths for the first-order-section output stage and the
//          sat_round() helper that rounds a wide signed value half-up and
//          saturates it to a narrower signed sample, returning a saturation bit.
// Ports:   none (package).
// Build:   FOS_QUANT_STATS_EN is consumed by fos_out_quant, not by this package.

package fos_pkg;

    localparam int FOS_IN_W  = 32;
    localparam int FOS_OUT_W = 16;
    localparam int FOS_SHIFT = 10;
    localparam int FOS_CNT_W = 16;
    localparam int FOS_DEPTH = 4;

    // sample holds the saturated result sign-extended to 64 bits.
    typedef struct packed {
        logic               sat;
        logic signed [63:0] sample;
    } fos_q_t;

    // Round half-up (toward +inf) by dropping `shift` fraction bits, then clamp
    // to the signed range of `out_w` bits. A shift of 0 only clamps.
    function automatic fos_q_t sat_round(input logic signed [63:0] value,
                                         input int                 shift,
                                         input int                 out_w);
        fos_q_t             q;
        logic signed [63:0] r;
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        r = value;
        if (shift > 0) begin
            r = (value + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        maxv     = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        minv     = -maxv - 64'sd1;
        q.sat    = 1'b0;
        q.sample = r;
        if (r > maxv) begin
            q.sat    = 1'b1;
            q.sample = maxv;
        end else if (r < minv) begin
            q.sat    = 1'b1;
            q.sample = minv;
        end
        return q;
    endfunction

endpackage

// File: rtl/fos_sync_fifo.sv
// rtl/fos_sync_fifo.sv - parameterised synchronous FIFO with push-while-full-and-pop
//
// Purpose: single-clock FIFO. A push is accepted when not full, or when full
//          and a pop happens in the same cycle (count then stays at DEPTH).
//          Pops on an empty FIFO and unacceptable pushes are ignored.
// Ports:   clk, reset (sync, active-high)
//          i_push/i_data  write request and data
//          i_pop          read request (head is consumed at the clock edge)
//          o_data         head entry, 0 while empty
//          o_full/o_empty occupancy flags
//          o_count        number of stored entries (0..DEPTH)

module fos_sync_fifo #(
    parameter  int W     = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [AW:0]  o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointers are exactly log2(DEPTH) bits wide so they wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/fos_out_quant.sv
// rtl/fos_out_quant.sv - round/saturate output stage with sample FIFO and statistics
//
// Purpose: takes the IIR section's signed result every cycle, removes SHIFT
//          fraction bits with round-half-up, saturates to OUT_W bits and
//          queues the samples for a valid/ready sink. Samples arriving while
//          the FIFO is full and not being drained are dropped.
// Ports:   clk, reset (sync, active-high)
//          in_valid/in_data     filter result (no backpressure)
//          out_valid/out_ready  sink handshake, out_data = FIFO head
//          sat_flag/sat_count   sticky flag and saturating count of clamped samples
//          drop_flag/drop_count sticky flag and saturating count of dropped samples
// Build:   FOS_QUANT_STATS_EN builds the flag/counter logic; without it the four
//          statistics outputs are constant 0.

module fos_out_quant
    import fos_pkg::*;
#(
    parameter int IN_W  = FOS_IN_W,
    parameter int OUT_W = FOS_OUT_W,
    parameter int SHIFT = FOS_SHIFT,
    parameter int DEPTH = FOS_DEPTH,
    parameter int CNT_W = FOS_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             sat_flag,
    output logic             drop_flag,
    output logic [CNT_W-1:0] sat_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int AW = $clog2(DEPTH);

    // One guard bit above IN_W so that adding the rounding constant to the
    // largest positive input cannot wrap negative.
    localparam logic signed [IN_W:0] RND  = $signed((IN_W+1)'(1) << (SHIFT - 1));
    localparam logic signed [IN_W:0] MAXV = $signed((IN_W+1)'((1 << (OUT_W - 1)) - 1));
    localparam logic signed [IN_W:0] MINV = -MAXV - 1;

    logic signed [IN_W:0] w_s1_sum;
    logic signed [IN_W:0] r_s1_val;
    logic                 r_s1_valid;
    logic [OUT_W-1:0]     w_s2_data;
    logic                 w_s2_sat;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [AW:0]          w_fifo_count;

    // Stage 1: round half-up by adding half an output LSB before the shift.
    assign w_s1_sum = $signed({in_data[IN_W-1], in_data}) + RND;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_val   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_val   <= w_s1_sum >>> SHIFT;
        end
    end

    // Stage 2: clamp to the output range; the FIFO write is its register.
    always_comb begin
        w_s2_sat  = 1'b0;
        w_s2_data = r_s1_val[OUT_W-1:0];
        if (r_s1_val > MAXV) begin
            w_s2_sat  = 1'b1;
            w_s2_data = MAXV[OUT_W-1:0];
        end else if (r_s1_val < MINV) begin
            w_s2_sat  = 1'b1;
            w_s2_data = MINV[OUT_W-1:0];
        end
    end

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_push    = r_s1_valid && (!w_full || w_pop);

    fos_sync_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_s2_data),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

`ifdef FOS_QUANT_STATS_EN
    logic             w_drop;
    logic             r_sat_flag;
    logic             r_drop_flag;
    logic [CNT_W-1:0] r_sat_count;
    logic [CNT_W-1:0] r_drop_count;

    assign w_drop = r_s1_valid && (w_fifo_count == (AW+1)'(DEPTH)) && !w_pop;

    // A clamped sample counts whether it was stored or dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat_flag   <= 1'b0;
            r_drop_flag  <= 1'b0;
            r_sat_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (r_s1_valid && w_s2_sat) begin
                r_sat_flag <= 1'b1;
                if (r_sat_count != '1) begin
                    r_sat_count <= r_sat_count + CNT_W'(1);
                end
            end
            if (w_drop) begin
                r_drop_flag <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + CNT_W'(1);
                end
            end
        end
    end

    assign sat_flag   = r_sat_flag;
    assign drop_flag  = r_drop_flag;
    assign sat_count  = r_sat_count;
    assign drop_count = r_drop_count;
`else
    logic w_unused;
    assign w_unused   = ^{w_fifo_count, w_s2_sat};
    assign sat_flag   = 1'b0;
    assign drop_flag  = 1'b0;
    assign sat_count  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fos_out_quant.sv
// tb/tb_fos_out_quant.sv - self-checking bench for fos_out_quant

module tb_fos_out_quant;
    import fos_pkg::*;

    localparam int DEPTH = 4;
`ifdef FOS_QUANT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        out_valid, sat_flag, drop_flag;
    logic [15:0] out_data, sat_count, drop_count;
    logic        out_valid4, sat_flag4, drop_flag4;
    logic [15:0] out_data4;
    logic [3:0]  sat_count4, drop_count4;

    fos_out_quant #(.IN_W(32), .OUT_W(16), .SHIFT(10), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_flag(sat_flag), .drop_flag(drop_flag),
        .sat_count(sat_count), .drop_count(drop_count)
    );

    fos_out_quant #(.IN_W(32), .OUT_W(16), .SHIFT(10), .DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .sat_flag(sat_flag4), .drop_flag(drop_flag4),
        .sat_count(sat_count4), .drop_count(drop_count4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one pipeline slot, then a bounded queue of quantised samples.
    logic [15:0] mq[$];
    logic        mp_v = 1'b0;
    logic [31:0] mp_d = '0;
    int          sat_n = 0;
    int          drop_n = 0;
    bit          model_live = 1'b0;
    bit          m_pop;
    fos_q_t      m_q;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mp_v       = 1'b0;
            sat_n      = 0;
            drop_n     = 0;
            model_live = 1'b1;
        end else begin
            m_pop = (mq.size() > 0) && out_ready;
            if (m_pop) void'(mq.pop_front());
            if (mp_v) begin
                m_q = sat_round({{32{mp_d[31]}}, mp_d}, 10, 16);
                if (m_q.sat) sat_n++;
                if (mq.size() < DEPTH) mq.push_back(m_q.sample[15:0]);
                else drop_n++;
            end
            mp_v = in_valid;
            mp_d = in_data;
        end
    end

    function automatic logic [63:0] cap(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        if (!STATS) return 64'd0;
        return (n > mx) ? 64'(mx) : 64'(n);
    endfunction

    logic [15:0] seen[$];

    always @(negedge clk) begin
        if (model_live) begin
            chk("out_valid", out_valid, mq.size() > 0);
            chk("out_valid4", out_valid4, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("out_data", out_data, mq[0]);
                chk("out_data4", out_data4, mq[0]);
            end
            chk("sat_count", sat_count, cap(sat_n, 16));
            chk("drop_count", drop_count, cap(drop_n, 16));
            chk("sat_flag", sat_flag, STATS && sat_n > 0);
            chk("drop_flag", drop_flag, STATS && drop_n > 0);
            chk("sat_count4", sat_count4, cap(sat_n, 4));
            chk("drop_count4", drop_count4, cap(drop_n, 4));
            chk("sat_flag4", sat_flag4, STATS && sat_n > 0);
            chk("drop_flag4", drop_flag4, STATS && drop_n > 0);
            if (out_valid && out_ready) seen.push_back(out_data);
        end
    end

    logic [15:0] exp_q[$];

    task automatic check_seen(input string nm);
        chk({nm, "_n"}, seen.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < seen.size()) chk(nm, seen[i], exp_q[i]);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_flags", {sat_flag, drop_flag}, 0);

        // Rounding and two-cycle latency
        out_ready = 1'b1;
        step(1'b1, 32'h0000_0600);
        chk("lat_n1_valid", out_valid, 0);
        step(1'b1, 32'h0000_0200);
        chk("lat_n2_valid", out_valid, 1);
        chk("lat_n2_data", out_data, 16'h0002);
        step(1'b1, 32'hFFFF_FE00);
        step(1'b1, 32'hFFFF_FDFF);
        idle(4);
        exp_q = {16'h0002, 16'h0001, 16'h0000, 16'hFFFF};
        check_seen("round");

        // Saturation at both ends
        do_reset();
        out_ready = 1'b1;
        step(1'b1, 32'h7FFF_FFFF);
        step(1'b1, 32'h8000_0000);
        idle(3);
        exp_q = {16'h7FFF, 16'h8000};
        check_seen("sat");
        chk("sat_cnt_lit", sat_count, STATS ? 2 : 0);
        chk("sat_flag_lit", sat_flag, STATS);
        chk("sat_drop_lit", drop_count, 0);

        // Overflow with sink stalled
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) step(1'b1, 32'(k) << 10);
        idle(2);
        chk("ovf_drop_lit", drop_count, STATS ? 2 : 0);
        chk("ovf_dflag_lit", drop_flag, STATS);
        chk("ovf_valid", out_valid, 1);
        out_ready = 1'b1;
        idle(6);
        exp_q = {16'd1, 16'd2, 16'd3, 16'd4};
        check_seen("ovf");
        chk("ovf_empty", out_valid, 0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) step(1'b1, 32'(k) << 10);
        idle(1);
        out_ready = 1'b1;
        for (int k = 5; k <= 12; k++) step(1'b1, 32'(k) << 10);
        idle(6);
        exp_q.delete();
        for (int k = 1; k <= 12; k++) exp_q.push_back(16'(k));
        check_seen("pushpop");
        chk("pushpop_drop", drop_count, 0);

        // Reset with samples in flight and in the FIFO
        do_reset();
        out_ready = 1'b0;
        step(1'b1, 32'h7FFF_FFFF);
        step(1'b1, 32'd2 << 10);
        step(1'b1, 32'd3 << 10);
        step(1'b1, 32'd4 << 10);
        chk("mid_pre_sat", sat_count, STATS ? 1 : 0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd5 << 10;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mid_valid", out_valid, 0);
        chk("mid_data", out_data, 0);
        chk("mid_sat", sat_count, 0);
        chk("mid_flag", sat_flag, 0);
        seen.delete();
        out_ready = 1'b1;
        idle(5);
        chk("mid_seen_n", seen.size(), 0);

        // Counter saturation on the 4-bit instance
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, (i % 2 != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF);
        idle(3);
        chk("cnt4_hold", sat_count4, STATS ? 15 : 0);
        chk("cnt16", sat_count, STATS ? 20 : 0);
        chk("cnt_seen_n", seen.size(), 20);
        if (seen.size() >= 2) begin
            chk("cnt_first", seen[0], 16'h7FFF);
            chk("cnt_second", seen[1], 16'h8000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
